// File: rtl/cache_controller.sv
// Per-request cache controller FSM: decodes hits into set control words and sequences
// dirty-victim write-back followed by word-by-word refill on a miss.
module cache_controller #(
    parameter int TAG_WIDTH    = 26,
    parameter int SET_WIDTH    = 2,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 mem_ready_i,
    output logic [4:0]           control_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 ready_o
);

    localparam int CNT_WIDTH = OFFSET_WIDTH - 2;
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = '1;

    // control_o = {write_en, set_valid, set_dirty, strategy_en, offset_sel}
    localparam logic [4:0] CTRL_IDLE      = 5'b00000;
    localparam logic [4:0] CTRL_READ_HIT  = 5'b00011;
    localparam logic [4:0] CTRL_WRITE_HIT = 5'b11111;
    localparam logic [4:0] CTRL_MISS      = 5'b00010;
    localparam logic [4:0] CTRL_FILL_WAIT = 5'b01000;
    localparam logic [4:0] CTRL_FILL_WORD = 5'b11000;

    typedef enum logic [1:0] {
        COMPARE    = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   request;
    logic                   unused_offset;

    assign request       = read_i | write_i;
    assign unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= COMPARE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        control_o   = CTRL_IDLE;
        mem_addr_o  = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        ready_o     = 1'b1;

        case (state_q)
            COMPARE: begin
                if (request) begin
                    if (hit_i) begin
                        control_o = write_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
                    end else begin
                        // strategy_en during the miss cycle lets the set latch its victim way.
                        control_o = CTRL_MISS;
                        ready_o   = 1'b0;
                        cnt_d     = '0;
                        state_d   = dirty_i ? WRITE_BACK : ALLOCATE;
                    end
                end
            end

            WRITE_BACK: begin
                ready_o     = 1'b0;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_i, addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH], cnt_q, 2'b00};
                if (mem_ready_i) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = ALLOCATE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            ALLOCATE: begin
                ready_o    = 1'b0;
                mem_read_o = 1'b1;
                mem_addr_o = {addr_i[31:OFFSET_WIDTH], cnt_q, 2'b00};
                control_o  = mem_ready_i ? CTRL_FILL_WORD : CTRL_FILL_WAIT;
                if (mem_ready_i) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = COMPARE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = COMPARE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with W=4 words per line.
module tb_cache_controller;

    localparam int TAG_WIDTH    = 26;
    localparam int SET_WIDTH    = 2;
    localparam int OFFSET_WIDTH = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 read_i, write_i;
    logic [31:0]          addr_i;
    logic                 hit_i, dirty_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic                 mem_ready_i;
    logic [4:0]           control_o;
    logic [31:0]          mem_addr_o;
    logic                 mem_read_o, mem_write_o, ready_o;

    int checks = 0;
    int errors = 0;

    cache_controller #(
        .TAG_WIDTH(TAG_WIDTH), .SET_WIDTH(SET_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .read_i(read_i), .write_i(write_i),
        .addr_i(addr_i), .hit_i(hit_i), .dirty_i(dirty_i), .tag_i(tag_i),
        .mem_ready_i(mem_ready_i), .control_o(control_o), .mem_addr_o(mem_addr_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic test_reset();
        rst_i = 1'b1; read_i = 0; write_i = 0; addr_i = '0; hit_i = 0; dirty_i = 0;
        tag_i = '0; mem_ready_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (control_o !== 5'b00000) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", control_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if ({mem_read_o, mem_write_o} !== 2'b00) begin errors++; $display("FAIL reset_mem_req: got %b expected 00", {mem_read_o, mem_write_o}); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr_o); end
        @(negedge clk_i); rst_i = 1'b0;
        @(negedge clk_i); #1;
        checks++; if (ready_o !== 1'b1 || control_o !== 5'b00000) begin errors++; $display("FAIL idle_after_reset: got ready=%b ctrl=%b expected ready=1 ctrl=00000", ready_o, control_o); end
    endtask

    task automatic test_hits();
        @(negedge clk_i); read_i = 1; write_i = 0; addr_i = 32'h40; hit_i = 1; #1;
        checks++; if (control_o !== 5'b00011 || ready_o !== 1'b1) begin errors++; $display("FAIL read_hit: got ctrl=%b ready=%b expected ctrl=00011 ready=1", control_o, ready_o); end
        checks++; if (mem_read_o !== 1'b0 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL read_hit_mem: got rd=%b addr=%h expected rd=0 addr=00000000", mem_read_o, mem_addr_o); end
        @(negedge clk_i); read_i = 0; write_i = 1; #1;
        checks++; if (control_o !== 5'b11111 || ready_o !== 1'b1) begin errors++; $display("FAIL write_hit: got ctrl=%b ready=%b expected ctrl=11111 ready=1", control_o, ready_o); end
        @(negedge clk_i); write_i = 0; hit_i = 0;
    endtask

    task automatic test_clean_miss();
        int stall_cycles;
        int write_pulses;
        logic [4:0] exp_ctrl;
        @(negedge clk_i); read_i = 1; write_i = 0; addr_i = 32'h1234; hit_i = 0; dirty_i = 0; #1;
        checks++; if (control_o !== 5'b00010 || ready_o !== 1'b0) begin errors++; $display("FAIL clean_miss_cycle: got ctrl=%b ready=%b expected ctrl=00010 ready=0", control_o, ready_o); end
        stall_cycles = 1;
        write_pulses = 0;
        for (int w = 0; w < 4; w++) begin
            for (int l = 0; l < 3; l++) begin
                @(negedge clk_i); mem_ready_i = (l == 2); #1;
                exp_ctrl = (l == 2) ? 5'b11000 : 5'b01000;
                checks++; if (mem_addr_o !== 32'h1230 + 32'(4 * w)) begin errors++; $display("FAIL refill_addr w%0d: got %h expected %h", w, mem_addr_o, 32'h1230 + 32'(4 * w)); end
                checks++; if (control_o !== exp_ctrl) begin errors++; $display("FAIL refill_ctrl w%0d: got %b expected %b", w, control_o, exp_ctrl); end
                checks++; if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0) begin errors++; $display("FAIL refill_req w%0d: got rd=%b wr=%b expected rd=1 wr=0", w, mem_read_o, mem_write_o); end
                if (ready_o === 1'b0) stall_cycles++;
                if (control_o[4] === 1'b1) write_pulses++;
            end
        end
        @(negedge clk_i); mem_ready_i = 0; hit_i = 1; #1;
        checks++; if (control_o !== 5'b00011 || ready_o !== 1'b1 || mem_read_o !== 1'b0) begin errors++; $display("FAIL clean_miss_hit: got ctrl=%b ready=%b rd=%b expected ctrl=00011 ready=1 rd=0", control_o, ready_o, mem_read_o); end
        checks++; if (stall_cycles !== 13) begin errors++; $display("FAIL clean_miss_stall: got %0d expected 13", stall_cycles); end
        checks++; if (write_pulses !== 4) begin errors++; $display("FAIL clean_miss_write_pulses: got %0d expected 4", write_pulses); end
        @(negedge clk_i); read_i = 0; hit_i = 0;
    endtask

    task automatic test_dirty_miss();
        @(negedge clk_i); read_i = 0; write_i = 1; addr_i = 32'h2008; hit_i = 0; dirty_i = 1;
        tag_i = 26'h1; #1;
        checks++; if (control_o !== 5'b00010 || ready_o !== 1'b0) begin errors++; $display("FAIL dirty_miss_cycle: got ctrl=%b ready=%b expected ctrl=00010 ready=0", control_o, ready_o); end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk_i); mem_ready_i = 1; dirty_i = 0; #1;
            checks++; if (mem_addr_o !== 32'h40 + 32'(4 * w)) begin errors++; $display("FAIL wb_addr w%0d: got %h expected %h", w, mem_addr_o, 32'h40 + 32'(4 * w)); end
            checks++; if (mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || control_o !== 5'b00000 || ready_o !== 1'b0) begin
                errors++; $display("FAIL wb_outputs w%0d: got wr=%b rd=%b ctrl=%b ready=%b expected wr=1 rd=0 ctrl=00000 ready=0", w, mem_write_o, mem_read_o, control_o, ready_o);
            end
        end
        for (int w = 0; w < 4; w++) begin
            for (int l = 0; l < 2; l++) begin
                // hit_i is raised during refill and must be ignored outside COMPARE.
                @(negedge clk_i); mem_ready_i = (l == 1); hit_i = 1; #1;
                checks++; if (mem_addr_o !== 32'h2000 + 32'(4 * w)) begin errors++; $display("FAIL alloc_addr w%0d: got %h expected %h", w, mem_addr_o, 32'h2000 + 32'(4 * w)); end
                checks++; if (mem_read_o !== 1'b1 || mem_write_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL alloc_req w%0d: got rd=%b wr=%b ready=%b expected rd=1 wr=0 ready=0", w, mem_read_o, mem_write_o, ready_o); end
            end
        end
        @(negedge clk_i); mem_ready_i = 0; hit_i = 1; #1;
        checks++; if (control_o !== 5'b11111 || ready_o !== 1'b1) begin errors++; $display("FAIL dirty_miss_hit: got ctrl=%b ready=%b expected ctrl=11111 ready=1", control_o, ready_o); end
        @(negedge clk_i); write_i = 0; hit_i = 0;
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk_i); read_i = 1; write_i = 0; addr_i = 32'h1234; hit_i = 0; dirty_i = 0;
        @(negedge clk_i); mem_ready_i = 1;
        @(negedge clk_i); mem_ready_i = 0; #1;
        checks++; if (mem_addr_o !== 32'h1234 || mem_read_o !== 1'b1) begin errors++; $display("FAIL second_word_addr: got addr=%h rd=%b expected addr=00001234 rd=1", mem_addr_o, mem_read_o); end
        @(negedge clk_i); #1; rst_i = 1; #1;
        checks++; if (mem_read_o !== 1'b0 || mem_addr_o !== 32'h0 || control_o !== 5'b00010) begin
            errors++; $display("FAIL async_reset: got rd=%b addr=%h ctrl=%b expected rd=0 addr=00000000 ctrl=00010", mem_read_o, mem_addr_o, control_o);
        end
        read_i = 0; #1;
        checks++; if (ready_o !== 1'b1 || control_o !== 5'b00000 || mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_idle: got ready=%b ctrl=%b wr=%b expected ready=1 ctrl=00000 wr=0", ready_o, control_o, mem_write_o); end
        @(negedge clk_i); rst_i = 0;
        @(negedge clk_i); read_i = 1; #1;
        checks++; if (control_o !== 5'b00010) begin errors++; $display("FAIL restart_miss: got %b expected 00010", control_o); end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk_i); mem_ready_i = 1; #1;
            checks++; if (mem_addr_o !== 32'h1230 + 32'(4 * w)) begin errors++; $display("FAIL restart_addr w%0d: got %h expected %h", w, mem_addr_o, 32'h1230 + 32'(4 * w)); end
        end
        @(negedge clk_i); mem_ready_i = 0; hit_i = 1; #1;
        checks++; if (ready_o !== 1'b1 || control_o !== 5'b00011) begin errors++; $display("FAIL restart_hit: got ready=%b ctrl=%b expected ready=1 ctrl=00011", ready_o, control_o); end
        @(negedge clk_i); read_i = 0; hit_i = 0;
    endtask

    task automatic test_priority_and_stray_ready();
        @(negedge clk_i); read_i = 1; write_i = 1; hit_i = 1; addr_i = 32'h80; #1;
        checks++; if (control_o !== 5'b11111 || ready_o !== 1'b1) begin errors++; $display("FAIL write_priority: got ctrl=%b ready=%b expected ctrl=11111 ready=1", control_o, ready_o); end
        @(negedge clk_i); read_i = 0; write_i = 0; hit_i = 0; mem_ready_i = 1; #1;
        checks++; if (control_o !== 5'b00000 || ready_o !== 1'b1 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0) begin
            errors++; $display("FAIL stray_ready: got ctrl=%b ready=%b rd=%b wr=%b expected ctrl=00000 ready=1 rd=0 wr=0", control_o, ready_o, mem_read_o, mem_write_o);
        end
        @(negedge clk_i); mem_ready_i = 0; read_i = 1; addr_i = 32'h40; #1;
        checks++; if (control_o !== 5'b00010) begin errors++; $display("FAIL miss_after_stray: got %b expected 00010", control_o); end
        @(negedge clk_i); #1;
        checks++; if (mem_addr_o !== 32'h40 || mem_read_o !== 1'b1) begin errors++; $display("FAIL cnt_after_stray: got addr=%h rd=%b expected addr=00000040 rd=1", mem_addr_o, mem_read_o); end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk_i); mem_ready_i = 1;
        end
        @(negedge clk_i); mem_ready_i = 0; hit_i = 1; #1;
        checks++; if (ready_o !== 1'b1 || mem_read_o !== 1'b0) begin errors++; $display("FAIL final_hit: got ready=%b rd=%b expected ready=1 rd=0", ready_o, mem_read_o); end
        @(negedge clk_i); read_i = 0; hit_i = 0;
    endtask

    initial begin
        test_reset();
        test_hits();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_refill();
        test_priority_and_stray_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Per-request finite-state machine that sits directly upstream of the cache sets. It decodes processor read/write requests and the selected set's hit/dirty/tag status into the 5-bit set control word. On a miss it sequences word-by-word write-back of a dirty victim, then refill from memory, and stalls the processor until the access can complete as a hit.

## Interface
- TAG_WIDTH, `CACHE_T: address tag bits.
- SET_WIDTH, `CACHE_S: set index bits.
- OFFSET_WIDTH, `CACHE_B: byte-offset bits per line; words per line W = 2^(OFFSET_WIDTH-2).
- clk_i  in  1  clock; one clock for everything.
- rst_i  in  1  reset, asynchronous, active-high.
- read_i  in  1  processor read request.
- write_i  in  1  processor write request; if both are set, the request is treated as a write.
- addr_i  in  32  request address; must be held stable while ready_o=0.
- hit_i  in  1  selected set reports a hit.
- dirty_i  in  1  selected set's target/victim line is dirty.
- tag_i  in  TAG_WIDTH  tag of the victim line.
- mem_ready_i  in  1  one-cycle pulse: memory has completed the current word.
- control_o  out  5  {write_en, set_valid, set_dirty, strategy_en, offset_sel} to the sets.
- mem_addr_o  out  32  word address for memory and the set's refill offset.
- mem_read_o  out  1  memory read request, held per word.
- mem_write_o  out  1  memory write request, held per word.
- ready_o  out  1  request completes this cycle (0 = stall processor).

## Operation
- States: COMPARE, WRITE_BACK, ALLOCATE. Word counter cnt has width OFFSET_WIDTH-2.
- COMPARE, no request: control_o=0, mem_read_o=mem_write_o=0, mem_addr_o=0, ready_o=1.
- COMPARE, read hit: control_o=00011, ready_o=1, stay in COMPARE.
- COMPARE, write hit: control_o=11111, ready_o=1, stay in COMPARE.
- COMPARE, miss (request & ~hit_i): control_o=00010, so strategy_en fixes the victim. ready_o=0, cnt<=0.
  - Next state is WRITE_BACK if dirty_i, otherwise ALLOCATE.
- WRITE_BACK:
  - mem_write_o=1, mem_addr_o={tag_i, addr_i index, cnt, 2'b00}.
  - control_o=00000: offset_sel=0, so the set reads the victim word at mem_addr_o; the memory write data is the set read data, wired outside this block.
  - On mem_ready_i: cnt++. On the last word (cnt==W-1), cnt<=0 and next state is ALLOCATE.
- ALLOCATE:
  - mem_read_o=1, mem_addr_o={addr_i[31:OFFSET_WIDTH], cnt, 2'b00}.
  - control_o=11000 while mem_ready_i=1, otherwise 01000: write memory data into the victim line, valid set, dirty clear.
  - On mem_ready_i: cnt++. On the last word, cnt<=0 and next state is COMPARE.
  - COMPARE then re-evaluates the request: it now hits and completes there; a write sets the line dirty.
- ready_o=0 in WRITE_BACK and ALLOCATE.
- Only state and cnt are registered; all outputs are combinational decodes of state, cnt, the request and the set status.

## Timing
- Reset: state=COMPARE, cnt=0. With no request, control_o=0, mem_*_o=0, mem_addr_o=0, ready_o=1.
- Asynchronous reset mid-WRITE_BACK or mid-ALLOCATE abandons the transfer immediately. The partially refilled line is left as written; this is permitted because the next miss rewrites it.
- Hit latency: 0 extra cycles; ready_o is asserted in the same cycle as the request.
- Clean miss: 1 COMPARE cycle + W memory words + 1 COMPARE hit cycle.
- Dirty miss: additionally W write-back words before refill.
- Memory handshake:
  - The request level is held until mem_ready_i. Each mem_ready_i advances exactly one word.
  - mem_ready_i with no request outstanding is ignored.
  - Back-to-back mem_ready_i pulses are legal (1 word/cycle).
- cnt wraps from W-1 to 0 only on a state transition; it never rolls over in place.
- Hit and miss decisions are sampled only in COMPARE; hit_i and dirty_i are ignored elsewhere.

## Test plan
Bench parameters: OFFSET_WIDTH=4 (W=4), SET_WIDTH=2, TAG_WIDTH=26.
- Reset, no request: control_o=00000, ready_o=1, mem_read_o=mem_write_o=0, mem_addr_o=0.
- Read hit at 0x40 with hit_i=1: same-cycle control_o=00011, ready_o=1; write hit gives 11111.
- Clean read miss at 0x1234, memory latency 3 cycles/word:
  - Miss cycle control_o=00010.
  - mem_addr_o steps 0x1230, 0x1234, 0x1238, 0x123C; write_en pulses 4 times, one per mem_ready_i.
  - Then COMPARE with hit_i=1 gives ready_o=1; total stall is 1+12 cycles.
- Dirty write miss at 0x2008, tag_i=0x1 (with W=4 the index bits are zero):
  - 4 writes to 0x40..0x4C with mem_write_o=1 and offset_sel=0.
  - Then 4 refills from 0x2000..0x200C, then control_o=11111 with ready_o=1.
- Reset asserted during the 2nd refill word: outputs return to reset values asynchronously, and the next miss restarts at cnt=0.
- read_i=write_i=1 on a hit gives control_o=11111 (write priority); mem_ready_i pulsed while in COMPARE is ignored.
